// File: rtl/hsv_core_pkg.sv
// Shared ALU decode types: issue opcodes, decoded ALU control word and the
// decode-stage FIFO entry.
package hsv_core_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADDI, ALU_SUB,
    ALU_AND, ALU_ANDI, ALU_OR, ALU_ORI, ALU_XOR, ALU_XORI,
    ALU_SLL, ALU_SLLI, ALU_SRL, ALU_SRLI, ALU_SRA, ALU_SRAI,
    ALU_SLT, ALU_SLTI, ALU_SLTU, ALU_SLTIU,
    ALU_LUI, ALU_AUIPC
  } alu_opcode;

  typedef enum logic {
    ALU_OUT_ADDER,
    ALU_OUT_SHIFT
  } alu_out_t;

  typedef enum logic [1:0] {
    ALU_BITWISE_PASS,
    ALU_BITWISE_AND,
    ALU_BITWISE_OR,
    ALU_BITWISE_XOR
  } alu_bitwise_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] immediate;
    logic [4:0]  rd;
  } exec_mem_common_t;

  typedef struct packed {
    exec_mem_common_t common;
    logic             illegal;
    alu_out_t         out_select;
    alu_bitwise_t     bitwise_select;
    logic             negate;
    logic             flip_signs;
    logic             sign_extend;
    logic             is_immediate;
    logic             compare;
    logic             pc_relative;
  } alu_data_t;

  typedef struct packed {
    alu_data_t data;
    logic      bad_opcode;
  } alu_decoded_t;

endpackage

// File: rtl/hsv_core_alu_decoder.sv
// Combinational ALU opcode decoder; unknown opcodes are flagged and, when
// trapping is enabled, raise illegal.
module hsv_core_alu_decoder
  import hsv_core_pkg::*;
#(
  parameter bit TRAP_BAD_OPCODE = 1'b1
) (
  input  alu_opcode        i_opcode,
  input  logic             i_illegal,
  input  exec_mem_common_t i_common,
  output alu_decoded_t     o_decoded
);

  always_comb begin
    o_decoded             = '0;
    o_decoded.data.common = i_common;
    o_decoded.data.illegal = i_illegal;
    case (i_opcode)
      ALU_ADD: ;
      ALU_ADDI: o_decoded.data.is_immediate = 1'b1;
      ALU_SUB:  o_decoded.data.negate = 1'b1;
      ALU_AND, ALU_ANDI: begin
        o_decoded.data.out_select     = ALU_OUT_SHIFT;
        o_decoded.data.bitwise_select = ALU_BITWISE_AND;
        o_decoded.data.is_immediate   = (i_opcode == ALU_ANDI);
      end
      ALU_OR, ALU_ORI: begin
        o_decoded.data.out_select     = ALU_OUT_SHIFT;
        o_decoded.data.bitwise_select = ALU_BITWISE_OR;
        o_decoded.data.is_immediate   = (i_opcode == ALU_ORI);
      end
      ALU_XOR, ALU_XORI: begin
        o_decoded.data.out_select     = ALU_OUT_SHIFT;
        o_decoded.data.bitwise_select = ALU_BITWISE_XOR;
        o_decoded.data.is_immediate   = (i_opcode == ALU_XORI);
      end
      // Left shifts reuse the right shifter on a bit-reversed operand.
      ALU_SLL, ALU_SLLI: begin
        o_decoded.data.out_select   = ALU_OUT_SHIFT;
        o_decoded.data.negate       = 1'b1;
        o_decoded.data.is_immediate = (i_opcode == ALU_SLLI);
      end
      ALU_SRL, ALU_SRLI: begin
        o_decoded.data.out_select   = ALU_OUT_SHIFT;
        o_decoded.data.is_immediate = (i_opcode == ALU_SRLI);
      end
      ALU_SRA, ALU_SRAI: begin
        o_decoded.data.out_select   = ALU_OUT_SHIFT;
        o_decoded.data.sign_extend  = 1'b1;
        o_decoded.data.is_immediate = (i_opcode == ALU_SRAI);
      end
      ALU_SLT, ALU_SLTI, ALU_SLTU, ALU_SLTIU: begin
        o_decoded.data.compare      = 1'b1;
        o_decoded.data.negate       = 1'b1;
        o_decoded.data.flip_signs   = (i_opcode == ALU_SLT) || (i_opcode == ALU_SLTI);
        o_decoded.data.is_immediate = (i_opcode == ALU_SLTI) || (i_opcode == ALU_SLTIU);
      end
      ALU_LUI: o_decoded.data.is_immediate = 1'b1;
      ALU_AUIPC: begin
        o_decoded.data.is_immediate = 1'b1;
        o_decoded.data.pc_relative  = 1'b1;
      end
      default: begin
        o_decoded.bad_opcode   = 1'b1;
        o_decoded.data.illegal = TRAP_BAD_OPCODE;
      end
    endcase
  end

endmodule

// File: rtl/hsv_core_alu_decode_stage.sv
// Registered ALU decode stage: decodes issue packets into a small FIFO with
// backpressure, flush and a saturating unknown-opcode counter.
module hsv_core_alu_decode_stage
  import hsv_core_pkg::*;
#(
  parameter int FIFO_DEPTH      = 2,
  parameter int CNT_W           = 16,
  parameter bit TRAP_BAD_OPCODE = 1'b1
) (
  input  logic             clk_core,
  input  logic             rst_core_n,
  input  logic             flush_req,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_opcode        in_opcode,
  input  logic             in_illegal,
  input  exec_mem_common_t in_common,
  output logic             out_valid,
  input  logic             out_ready,
  output alu_data_t        out_alu_data,
  output logic             out_bad_opcode,
  output logic [CNT_W-1:0] bad_opcode_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);

  alu_decoded_t     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_occ;
  logic [CNT_W-1:0] r_bad_cnt;

  alu_decoded_t w_dec;
  logic         w_push;
  logic         w_pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  hsv_core_alu_decoder #(
    .TRAP_BAD_OPCODE(TRAP_BAD_OPCODE)
  ) u_decoder (
    .i_opcode (in_opcode),
    .i_illegal(in_illegal),
    .i_common (in_common),
    .o_decoded(w_dec)
  );

  // in_ready depends only on occupancy, never on out_ready.
  assign in_ready  = (r_occ != FULL_OCC);
  assign out_valid = (r_occ != '0);
  assign w_push    = in_valid & in_ready & ~flush_req;
  assign w_pop     = out_valid & out_ready & ~flush_req;

  assign out_alu_data     = r_mem[r_rd_ptr].data;
  assign out_bad_opcode   = r_mem[r_rd_ptr].bad_opcode;
  assign bad_opcode_count = r_bad_cnt;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_bad_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_req) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        if (w_dec.bad_opcode) r_bad_cnt <= sat_inc(r_bad_cnt);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_occ <= r_occ + 1'b1;
      else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
    end
  end

endmodule
